// File: rtl/edge_frame_streamer.sv
// Buffers a 20x20 frame from a pixel stream, bursts it into the edge-detection CHIP
// five pixels per cycle, then forwards the CHIP's edge bits downstream.
module edge_frame_streamer #(
    parameter int unsigned IMG_DIM    = 20,
    parameter int unsigned BIT_LENGTH = 5,
    parameter int unsigned GROUP      = 5,
    parameter int unsigned EDGE_CNT   = 324
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic [BIT_LENGTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic [BIT_LENGTH-1:0] pixel_out0,
    output logic [BIT_LENGTH-1:0] pixel_out1,
    output logic [BIT_LENGTH-1:0] pixel_out2,
    output logic [BIT_LENGTH-1:0] pixel_out3,
    output logic [BIT_LENGTH-1:0] pixel_out4,
    output logic                  load_end,
    output logic                  chip_reset,
    input  logic                  edge_in,
    input  logic                  edge_readable,
    output logic                  edge_valid,
    output logic                  edge_bit,
    output logic                  frame_busy
);

    localparam int unsigned PIX_CNT = IMG_DIM * IMG_DIM;
    localparam int unsigned GRP_NUM = PIX_CNT / GROUP;
    localparam int unsigned EW      = $clog2(EDGE_CNT + 1);

    typedef enum logic [1:0] {StFill, StBurst, StProcess} state_t;

    state_t          state_q, state_d;
    logic [8:0]      wr_cnt_q, wr_cnt_d;
    logic [6:0]      grp_cnt_q, grp_cnt_d;
    logic [EW-1:0]   edge_cnt_q, edge_cnt_d;
    logic            wr_en;
    logic [8:0]      base;

    logic [BIT_LENGTH-1:0] frame [PIX_CNT];

    // Frame storage is intentionally not reset; a new frame always overwrites from index 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame[wr_cnt_q] <= pix_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFill;
            wr_cnt_q   <= '0;
            grp_cnt_q  <= '0;
            edge_cnt_q <= '0;
            edge_valid <= 1'b0;
            edge_bit   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            edge_valid <= edge_readable;
            if (edge_readable) begin
                edge_bit <= edge_in;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        edge_cnt_d = edge_cnt_q;
        wr_en      = 1'b0;
        pix_ready  = 1'b0;
        chip_reset = 1'b0;
        load_end   = 1'b0;
        frame_busy = 1'b0;
        pixel_out0 = '0;
        pixel_out1 = '0;
        pixel_out2 = '0;
        pixel_out3 = '0;
        pixel_out4 = '0;
        base       = 9'(grp_cnt_q) * 9'(GROUP);

        unique case (state_q)
            StFill: begin
                pix_ready  = 1'b1;
                chip_reset = 1'b1;
                if (pix_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == 9'(PIX_CNT - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = StBurst;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 9'd1;
                    end
                end
            end
            StBurst: begin
                // Driven straight from grp_cnt so group 0 is present on the first
                // edge after chip_reset drops.
                frame_busy = 1'b1;
                pixel_out0 = frame[base];
                pixel_out1 = frame[base + 9'd1];
                pixel_out2 = frame[base + 9'd2];
                pixel_out3 = frame[base + 9'd3];
                pixel_out4 = frame[base + 9'd4];
                if (grp_cnt_q == 7'(GRP_NUM - 1)) begin
                    load_end  = 1'b1;
                    grp_cnt_d = '0;
                    state_d   = StProcess;
                end else begin
                    grp_cnt_d = grp_cnt_q + 7'd1;
                end
            end
            StProcess: begin
                frame_busy = 1'b1;
                if (edge_readable) begin
                    if (edge_cnt_q == EW'(EDGE_CNT - 1)) begin
                        edge_cnt_d = '0;
                        state_d    = StFill;
                    end else begin
                        edge_cnt_d = edge_cnt_q + EW'(1);
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

endmodule

// File: tb/tb_edge_frame_streamer.sv
// Self-checking bench for edge_frame_streamer: scoreboarded bursts plus a table of
// edge-forwarding vectors.
module tb_edge_frame_streamer;

    logic       clk;
    logic       reset;
    logic       pix_valid;
    logic [4:0] pix_data;
    logic       pix_ready;
    logic [4:0] pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4;
    logic       load_end;
    logic       chip_reset;
    logic       edge_in;
    logic       edge_readable;
    logic       edge_valid;
    logic       edge_bit;
    logic       frame_busy;

    edge_frame_streamer dut (
        .clk           (clk),
        .reset         (reset),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .pixel_out0    (pixel_out0),
        .pixel_out1    (pixel_out1),
        .pixel_out2    (pixel_out2),
        .pixel_out3    (pixel_out3),
        .pixel_out4    (pixel_out4),
        .load_end      (load_end),
        .chip_reset    (chip_reset),
        .edge_in       (edge_in),
        .edge_readable (edge_readable),
        .edge_valid    (edge_valid),
        .edge_bit      (edge_bit),
        .frame_busy    (frame_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [24:0] pix;
        logic        le;
    } grp_t;

    typedef struct packed {
        logic rd;
        logic din;
        logic ev;
        logic eb;
    } evec_t;

    grp_t       exp_q[$];
    evec_t      etab[8];
    logic [4:0] model [400];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       exp_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pat(input int kind, input int i);
        case (kind)
            0:       return 5'(i % 32);
            1:       return 5'((3 * i + 1) % 32);
            default: return 5'((5 * i + 2) % 32);
        endcase
    endfunction

    task automatic fill_frame(input int kind, input bit toggle);
        int acc = 0;
        int cyc = 0;
        grp_t r;
        while (acc < 400 && cyc < 3000) begin
            pix_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            pix_data  = pix_valid ? pat(kind, acc) : 5'($urandom);
            check("fill_ready", {31'd0, pix_ready}, 32'd1);
            step();
            if (pix_valid) begin
                model[acc] = pat(kind, acc);
                acc++;
            end
            cyc++;
        end
        pix_valid = 1'b0;
        if (acc < 400) begin
            check("fill_timeout", acc, 400);
        end
        for (int g = 0; g < 80; g++) begin
            r.pix = {model[5*g+4], model[5*g+3], model[5*g+2], model[5*g+1], model[5*g]};
            r.le  = (g == 79);
            exp_q.push_back(r);
        end
    endtask

    // Checks n groups of the burst that starts at the current sample point.
    task automatic check_burst(input int n);
        grp_t r;
        for (int g = 0; g < n; g++) begin
            if (exp_q.size() == 0) begin
                check("burst_queue_empty", 0, 1);
            end else begin
                r = exp_q.pop_front();
                check("burst_pix", {7'd0, pixel_out4, pixel_out3, pixel_out2, pixel_out1,
                                    pixel_out0}, {7'd0, r.pix});
                check("burst_load_end", {31'd0, load_end}, {31'd0, r.le});
            end
            check("burst_chip_reset", {31'd0, chip_reset}, 32'd0);
            check("burst_ready", {31'd0, pix_ready}, 32'd0);
            check("burst_busy", {31'd0, frame_busy}, 32'd1);
            pix_valid = g[0];
            pix_data  = 5'h1f;
            step();
        end
        pix_valid = 1'b0;
    endtask

    task automatic apply_etab(input logic busy);
        for (int i = 0; i < 8; i++) begin
            edge_readable = etab[i].rd;
            edge_in       = etab[i].din;
            step();
            check("etab_valid", {31'd0, edge_valid}, {31'd0, etab[i].ev});
            check("etab_bit", {31'd0, edge_bit}, {31'd0, etab[i].eb});
            check("etab_busy", {31'd0, frame_busy}, {31'd0, busy});
        end
        edge_readable = 1'b0;
        exp_bit = etab[7].eb;
    endtask

    // Table supplies pulses 1..4; this drives pulses 5..324 with occasional idle gaps.
    task automatic run_edges();
        for (int n = 5; n <= 324; n++) begin
            if (n % 5 == 0) begin
                edge_readable = 1'b0;
                edge_in       = 1'($urandom);
                step();
                check("idle_valid", {31'd0, edge_valid}, 32'd0);
                check("idle_bit", {31'd0, edge_bit}, {31'd0, exp_bit});
            end
            check("proc_busy", {31'd0, frame_busy}, 32'd1);
            edge_readable = 1'b1;
            edge_in       = (n % 2 == 1);
            exp_bit       = edge_in;
            step();
            check("pulse_valid", {31'd0, edge_valid}, 32'd1);
            check("pulse_bit", {31'd0, edge_bit}, {31'd0, exp_bit});
        end
        edge_readable = 1'b0;
        check("done_busy", {31'd0, frame_busy}, 32'd0);
        check("done_chip_reset", {31'd0, chip_reset}, 32'd1);
        check("done_ready", {31'd0, pix_ready}, 32'd1);
        step();
        check("done_valid_drop", {31'd0, edge_valid}, 32'd0);
    endtask

    task automatic check_process_entry();
        check("proc_load_end", {31'd0, load_end}, 32'd0);
        check("proc_pix0", {27'd0, pixel_out0}, 32'd0);
        check("proc_busy_entry", {31'd0, frame_busy}, 32'd1);
        check("proc_ready", {31'd0, pix_ready}, 32'd0);
        check("proc_chip_reset", {31'd0, chip_reset}, 32'd0);
    endtask

    initial begin
        //              rd    din   ev    eb
        etab[0] = '{1'b1, 1'b1, 1'b1, 1'b1};
        etab[1] = '{1'b0, 1'b0, 1'b0, 1'b1};
        etab[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        etab[3] = '{1'b0, 1'b1, 1'b0, 1'b0};
        etab[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        etab[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        etab[6] = '{1'b0, 1'b0, 1'b0, 1'b0};
        etab[7] = '{1'b0, 1'b1, 1'b0, 1'b0};

        reset         = 1'b1;
        pix_valid     = 1'b0;
        pix_data      = '0;
        edge_in       = 1'b0;
        edge_readable = 1'b0;
        exp_bit       = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        step();

        // Reset state held
        check("rst_ready", {31'd0, pix_ready}, 32'd1);
        check("rst_chip_reset", {31'd0, chip_reset}, 32'd1);
        check("rst_busy", {31'd0, frame_busy}, 32'd0);
        check("rst_pix", {7'd0, pixel_out4, pixel_out3, pixel_out2, pixel_out1, pixel_out0},
              32'd0);
        check("rst_load_end", {31'd0, load_end}, 32'd0);
        check("rst_edge_valid", {31'd0, edge_valid}, 32'd0);
        check("rst_edge_bit", {31'd0, edge_bit}, 32'd0);

        // Continuous fill, burst, full edge phase
        fill_frame(0, 1'b0);
        check_burst(80);
        check_process_entry();
        apply_etab(1'b1);
        run_edges();

        // Edge pulses during FILL are forwarded but not counted
        apply_etab(1'b0);

        // Throttled fill; PROCESS still needs all 324 pulses
        fill_frame(0, 1'b1);
        check_burst(80);
        check_process_entry();
        apply_etab(1'b1);
        run_edges();

        // Reset in the middle of a burst
        fill_frame(1, 1'b0);
        check_burst(40);
        reset = 1'b1;
        #1;
        check("midrst_chip_reset", {31'd0, chip_reset}, 32'd1);
        check("midrst_ready", {31'd0, pix_ready}, 32'd1);
        check("midrst_busy", {31'd0, frame_busy}, 32'd0);
        check("midrst_load_end", {31'd0, load_end}, 32'd0);
        step();
        reset = 1'b0;
        exp_q.delete();
        step();
        check("postrst_load_end", {31'd0, load_end}, 32'd0);
        fill_frame(2, 1'b0);
        check_burst(80);
        check_process_entry();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_frame_streamer.md
Name: edge_frame_streamer

Overview:
- Transmit-side companion of the edge-detection CHIP.
- Accepts a 20x20 5-bit image one pixel per beat over a valid/ready interface and buffers the full frame.
- Streams the frame into the CHIP as an unbroken 80-cycle burst of 5 pixels per cycle, asserting load_end on the last group.
- Holds the CHIP in reset between frames so its load index starts aligned, then forwards the CHIP's edge bits downstream.

Parameters:
- IMG_DIM, 20, image side length in pixels.
- BIT_LENGTH, 5, pixel width.
- GROUP, 5, pixels presented to the CHIP per cycle.
- EDGE_CNT, 324, edge_readable pulses per frame before the frame is complete.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  upstream pixel valid.
- pix_data  in  BIT_LENGTH  upstream pixel, raster order (row-major, index 0 first).
- pix_ready  out  1  block can accept a pixel.
- pixel_out0..pixel_out4  out  BIT_LENGTH each  pixel group to CHIP pixel_in0..4; pixel_outk = frame[5*g+k].
- load_end  out  1  to CHIP load_end; high with the last group.
- chip_reset  out  1  drives CHIP reset.
- edge_in  in  1  from CHIP edge_out.
- edge_readable  in  1  from CHIP readable.
- edge_valid  out  1  registered edge_readable, forwarded downstream.
- edge_bit  out  1  registered edge_in, forwarded downstream.
- frame_busy  out  1  high in BURST and PROCESS.

Behaviour:
- Reset values: state=FILL; wr_cnt=0; grp_cnt=0; edge_cnt=0; chip_reset=1; pix_ready=1; load_end=0; pixel_out*=0; edge_valid=0; edge_bit=0; frame_busy=0.
- Frame buffer: IMG_DIM*IMG_DIM x BIT_LENGTH registers. Contents are not cleared by reset.

State FILL:
- pix_ready=1. chip_reset=1. pixel_out* and load_end are 0.
- On pix_valid&&pix_ready, write buffer[wr_cnt] and increment wr_cnt.
- When the accepting beat has wr_cnt==399, next state is BURST and wr_cnt returns to 0.
- pix_valid while pix_ready=0 is ignored; nothing is stored.

State BURST:
- pix_ready=0. chip_reset=0 from the first BURST cycle.
- Outputs are combinational from the registered grp_cnt. The CHIP therefore samples group 0 on its first edge after reset release.
- Each cycle: pixel_outk=buffer[5*grp_cnt+k], then grp_cnt increments.
- load_end=1 only when grp_cnt==79. That is the same cycle group 79 is driven.
- After grp_cnt==79: next state is PROCESS, grp_cnt=0.
- Exactly 80 cycles with no gaps and no stall input.

State PROCESS:
- pix_ready=0. chip_reset=0. pixel_out*=0. load_end=0.
- Every cycle: edge_valid<=edge_readable and edge_bit<=edge_in, giving 1-cycle latency. edge_bit holds its value when edge_readable=0.
- edge_cnt increments on each edge_readable.
- When edge_readable is high with edge_cnt==EDGE_CNT-1: next state is FILL, edge_cnt=0, chip_reset=1 from the next cycle.
- edge_valid may be high in the first FILL cycle, carrying the final bit.
- edge_readable outside PROCESS is forwarded to edge_valid but not counted.

Counter widths:
- wr_cnt 9 bits. grp_cnt 7 bits. edge_cnt: $clog2(EDGE_CNT+1) bits.
- No wrap-around is reachable. Counters are compared to terminal values, never allowed to overflow.
- Index arithmetic 5*grp_cnt+k is computed at 9 bits.

Reset mid-operation:
- Any state returns to FILL with chip_reset=1 and all counters at 0.
- The partially filled frame is discarded; the next frame is written from index 0.

Test Plan:
1. Reset, then hold: pix_ready=1, chip_reset=1, frame_busy=0, all pixel_out*=0.
2. Feed pixels p[i]=i%32 for i=0..399 with pix_valid always high:
   - BURST starts on the cycle after beat 399.
   - First BURST cycle: outputs 0,1,2,3,4 with chip_reset=0.
   - Group 79: outputs 395%32..399%32 = 11,12,13,14,15 with load_end=1.
   - load_end is high for exactly 1 cycle; BURST lasts exactly 80 cycles.
3. Feed the frame with pix_valid toggling every other cycle:
   - Buffer contents are identical to scenario 2.
   - The burst is identical, with no gaps.
   - pix_ready=0 throughout BURST and PROCESS.
4. In PROCESS, drive 324 edge_readable pulses with edge_in alternating 1,0:
   - edge_valid/edge_bit mirror the inputs one cycle later.
   - After pulse 324, state is FILL, chip_reset=1, pix_ready=1.
5. Assert reset at grp_cnt=40:
   - load_end never asserts for that frame.
   - chip_reset=1 immediately.
   - A following full fill of 400 beats produces a correct burst.
6. Pulse edge_readable during FILL: edge_valid follows it, and after a new frame PROCESS still requires a full 324 pulses to complete.
